// File: rtl/sccb_reg_sequencer.sv
// Walks a {reg, data} table for one camera profile and issues SCCB register writes,
// with in-table delays, an END marker and bounded NACK retries.
module sccb_reg_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 6,
  parameter int PROF_W     = 1,
  parameter int DELAY_UNIT = 1000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PROF_W-1:0]        profile_sel,
  output logic [PROF_W+IDX_W-1:0]  rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_reg,
  output logic [DATA_W-1:0]        cmd_data,
  input  logic                     xfer_done,
  input  logic                     xfer_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         entry_idx,
  output logic [2:0]               dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are
  // both high; cmd_reg/cmd_data hold steady while cmd_valid is high.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_XFER = 3'd4,
    S_DELAY     = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PS_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(DELAY_UNIT - 1);

  state_t              r_state, w_next_state, w_adv_state;
  logic [PROF_W-1:0]   r_profile, w_next_profile;
  logic [IDX_W-1:0]    r_index, w_next_index, w_adv_index;
  logic [RT_W-1:0]     r_retry, w_next_retry;
  logic [ADDR_W-1:0]   r_cmd_reg, w_next_cmd_reg;
  logic [DATA_W-1:0]   r_cmd_data, w_next_cmd_data;
  logic [PS_W-1:0]     r_prescale, w_next_prescale;
  logic [DATA_W-1:0]   r_units, w_next_units;

  logic [ADDR_W-1:0]   w_rom_reg;
  logic [DATA_W-1:0]   w_rom_dat;
  logic                w_is_delay, w_is_end, w_last;

  assign w_rom_reg  = rom_data[ADDR_W+DATA_W-1:DATA_W];
  assign w_rom_dat  = rom_data[DATA_W-1:0];
  assign w_is_delay = &w_rom_reg;
  assign w_is_end   = w_is_delay && (&w_rom_dat);
  assign w_last     = &r_index;

  // The last slot of a profile ends the run even without an END word.
  assign w_adv_state = w_last ? S_DONE : S_FETCH;
  assign w_adv_index = w_last ? r_index : r_index + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_profile  <= '0;
      r_index    <= '0;
      r_retry    <= '0;
      r_cmd_reg  <= '0;
      r_cmd_data <= '0;
      r_prescale <= '0;
      r_units    <= '0;
    end else begin
      r_profile  <= w_next_profile;
      r_index    <= w_next_index;
      r_retry    <= w_next_retry;
      r_cmd_reg  <= w_next_cmd_reg;
      r_cmd_data <= w_next_cmd_data;
      r_prescale <= w_next_prescale;
      r_units    <= w_next_units;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_profile  = r_profile;
    w_next_index    = r_index;
    w_next_retry    = r_retry;
    w_next_cmd_reg  = r_cmd_reg;
    w_next_cmd_data = r_cmd_data;
    w_next_prescale = r_prescale;
    w_next_units    = r_units;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_next_state   = S_FETCH;
          w_next_profile = profile_sel;
          w_next_index   = '0;
          w_next_retry   = '0;
        end
      end
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_end) begin
          w_next_state = S_DONE;
        end else if (w_is_delay) begin
          if (w_rom_dat == '0) begin
            w_next_state = w_adv_state;
            w_next_index = w_adv_index;
          end else begin
            w_next_state    = S_DELAY;
            w_next_units    = w_rom_dat;
            w_next_prescale = PS_RELOAD;
          end
        end else begin
          w_next_state    = S_ISSUE;
          w_next_cmd_reg  = w_rom_reg;
          w_next_cmd_data = w_rom_dat;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) w_next_state = S_WAIT_XFER;
      end
      S_WAIT_XFER: begin
        if (xfer_nack) begin
          if (r_retry < RT_MAX) begin
            w_next_retry = r_retry + 1'b1;
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_ERROR;
          end
        end else if (xfer_done) begin
          w_next_retry = '0;
          w_next_state = w_adv_state;
          w_next_index = w_adv_index;
        end
      end
      S_DELAY: begin
        // Prescaler counts one unit; the unit counter counts units remaining.
        if (r_prescale == '0) begin
          if (r_units == DATA_W'(1)) begin
            w_next_state = w_adv_state;
            w_next_index = w_adv_index;
          end else begin
            w_next_units    = r_units - 1'b1;
            w_next_prescale = PS_RELOAD;
          end
        end else begin
          w_next_prescale = r_prescale - 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (r_state == S_ISSUE);
    busy      = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    done      = (r_state == S_DONE);
    error     = (r_state == S_ERROR);
  end

  assign rom_addr  = {r_profile, r_index};
  assign cmd_reg   = r_cmd_reg;
  assign cmd_data  = r_cmd_data;
  assign entry_idx = r_index;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Directed bench for sccb_reg_sequencer: table ROM model, SCCB responder and
// one task per scenario with hand-computed expectations.
module tb_sccb_reg_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_ISSUE = 3'd3,
                         S_DELAY = 3'd5, S_DONE = 3'd6, S_ERROR = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [0:0]  profile_sel;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        xfer_done = 1'b0;
  logic        xfer_nack = 1'b0;
  logic        busy, done, error;
  logic [5:0]  entry_idx;
  logic [2:0]  dbg_state;

  logic [15:0] rom [0:127];
  logic [15:0] got_q [$];
  int          hs_cnt = 0;
  int          resp_cnt = 0;
  int          plan [0:15];
  int          plan_n = 0;
  int          plan_base = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  sccb_reg_sequencer #(.DELAY_UNIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .profile_sel(profile_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .xfer_done(xfer_done), .xfer_nack(xfer_nack), .busy(busy), .done(done),
    .error(error), .entry_idx(entry_idx), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Table ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Record every accepted command.
  initial forever begin
    @(posedge clk);
    if (!reset && cmd_valid && cmd_ready) begin
      got_q.push_back({cmd_reg, cmd_data});
      hs_cnt = hs_cnt + 1;
    end
  end

  // Responder: one cycle after a handshake, report per plan (0 done, 1 nack, 2 both).
  initial forever begin
    int code;
    @(negedge clk);
    xfer_done = 1'b0;
    xfer_nack = 1'b0;
    if (hs_cnt != resp_cnt) begin
      code = ((resp_cnt - plan_base) < plan_n) ? plan[resp_cnt - plan_base] : 0;
      xfer_done = (code != 1);
      xfer_nack = (code != 0);
      resp_cnt  = resp_cnt + 1;
    end
  end

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  task automatic pulse_start(input logic [0:0] p);
    @(negedge clk);
    profile_sel = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({done, error} !== 2'b00) begin n_fail++; $display("FAIL reset_done_error: got %b want 00", {done, error}); end
    n_cmp++; if (entry_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", entry_idx); end
    n_cmp++; if (rom_addr !== 7'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
    n_cmp++; if ({cmd_reg, cmd_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", {cmd_reg, cmd_data}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_single_write;
    int base;
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h1280;
    plan_n = 0; plan_base = resp_cnt; base = got_q.size(); cmd_ready = 1'b1;
    pulse_start(1'b0);
    n_cmp++; if ({busy, dbg_state} !== {1'b1, S_FETCH}) begin n_fail++; $display("FAIL single_fetch: got busy=%b st=%0d want busy=1 st=1", busy, dbg_state); end
    wait_end(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got no end want done"); end
    n_cmp++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got_q.size() - base); end
    n_cmp++; if (got_q[base] !== 16'h1280) begin n_fail++; $display("FAIL single_cmd: got %h want 1280", got_q[base]); end
    n_cmp++; if ({done, busy, error} !== 3'b100) begin n_fail++; $display("FAIL single_flags: got %b want 100", {done, busy, error}); end
    n_cmp++; if (entry_idx !== 6'd1) begin n_fail++; $display("FAIL single_idx: got %0d want 1", entry_idx); end
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done_held: got %b want 1", done); end
  endtask

  task automatic test_delay;
    int base, cnt;
    logic [2:0] prev, exit_st;
    logic [5:0] exit_idx, dly_idx;
    fill_rom(16'hFFFF);
    rom[0] = 16'hFF00; rom[1] = 16'hFF05; rom[2] = 16'h1234;
    plan_n = 0; plan_base = resp_cnt; base = got_q.size();
    cnt = 0; prev = S_FETCH; exit_st = 3'd0; exit_idx = 6'h3F; dly_idx = 6'h3F;
    pulse_start(1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dbg_state == S_DELAY) begin cnt++; dly_idx = entry_idx; end
      if (prev == S_DELAY && dbg_state != S_DELAY) begin exit_st = dbg_state; exit_idx = entry_idx; end
      prev = dbg_state;
      if (done || error) break;
    end
    n_cmp++; if (cnt !== 20) begin n_fail++; $display("FAIL delay_cycles: got %0d want 20", cnt); end
    n_cmp++; if (dly_idx !== 6'd1) begin n_fail++; $display("FAIL delay_idx: got %0d want 1", dly_idx); end
    n_cmp++; if ({exit_st, exit_idx} !== {S_FETCH, 6'd2}) begin n_fail++; $display("FAIL delay_exit: got st=%0d idx=%0d want st=1 idx=2", exit_st, exit_idx); end
    n_cmp++; if (got_q.size() - base !== 1 || got_q[base] !== 16'h1234) begin n_fail++; $display("FAIL delay_cmd: got n=%0d %h want n=1 1234", got_q.size() - base, got_q[base]); end
    n_cmp++; if ({done, entry_idx} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL delay_end: got done=%b idx=%0d want done=1 idx=3", done, entry_idx); end
  endtask

  task automatic test_retry;
    int base;
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h2211;
    plan[0] = 1; plan[1] = 2; plan[2] = 1; plan[3] = 0; plan_n = 4;
    plan_base = resp_cnt; base = got_q.size();
    pulse_start(1'b0);
    wait_end(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL retry_timeout: got no end want done"); end
    n_cmp++; if (got_q.size() - base !== 4) begin n_fail++; $display("FAIL retry_count: got %0d want 4", got_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got_q[base + i] !== 16'h2211) begin n_fail++; $display("FAIL retry_cmd%0d: got %h want 2211", i, got_q[base + i]); end
    end
    n_cmp++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL retry_flags: got %b want 10", {done, error}); end
  endtask

  task automatic test_nack_error;
    int base;
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h0101; rom[1] = 16'h3344;
    plan[0] = 0; plan[1] = 1; plan[2] = 1; plan[3] = 2; plan[4] = 1; plan_n = 5;
    plan_base = resp_cnt; base = got_q.size();
    pulse_start(1'b0);
    wait_end(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL err_timeout: got no end want error"); end
    n_cmp++; if ({error, done, busy} !== 3'b100) begin n_fail++; $display("FAIL err_flags: got %b want 100", {error, done, busy}); end
    n_cmp++; if (got_q.size() - base !== 5) begin n_fail++; $display("FAIL err_count: got %0d want 5", got_q.size() - base); end
    n_cmp++; if (got_q[base + 4] !== 16'h3344) begin n_fail++; $display("FAIL err_last_cmd: got %h want 3344", got_q[base + 4]); end
    repeat (5) @(negedge clk);
    n_cmp++; if ({dbg_state, entry_idx, cmd_valid} !== {S_ERROR, 6'd1, 1'b0}) begin n_fail++; $display("FAIL err_frozen: got st=%0d idx=%0d v=%b want st=7 idx=1 v=0", dbg_state, entry_idx, cmd_valid); end
  endtask

  task automatic test_profile_busy;
    int base;
    bit msb_bad;
    fill_rom(16'hFFFF);
    rom[0] = 16'h1111; rom[64] = 16'h5566;
    plan_n = 0; plan_base = resp_cnt; base = got_q.size(); msb_bad = 1'b0;
    cmd_ready = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 6; i++) begin
      if (rom_addr[6] !== 1'b1) msb_bad = 1'b1;
      @(negedge clk);
    end
    profile_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({dbg_state, cmd_valid} !== {S_ISSUE, 1'b1}) begin n_fail++; $display("FAIL busy_start_state: got st=%0d v=%b want st=3 v=1", dbg_state, cmd_valid); end
    n_cmp++; if ({cmd_reg, cmd_data} !== 16'h5566) begin n_fail++; $display("FAIL busy_cmd_stable: got %h want 5566", {cmd_reg, cmd_data}); end
    n_cmp++; if (rom_addr !== 7'h40) begin n_fail++; $display("FAIL busy_rom_addr: got %h want 40", rom_addr); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rom_addr[6] !== 1'b1) msb_bad = 1'b1;
      if (done || error) break;
    end
    n_cmp++; if (msb_bad !== 1'b0) begin n_fail++; $display("FAIL prof_msb: got msb dropped want held 1"); end
    n_cmp++; if (got_q.size() - base !== 1 || got_q[base] !== 16'h5566) begin n_fail++; $display("FAIL prof_cmd: got n=%0d %h want n=1 5566", got_q.size() - base, got_q[base]); end
    n_cmp++; if ({done, entry_idx} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL prof_end: got done=%b idx=%0d want done=1 idx=1", done, entry_idx); end
  endtask

  task automatic test_no_end;
    int base, bad;
    bit seen_last, wrapped;
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      rom[i] = {b, ~b};
    end
    plan_n = 0; plan_base = resp_cnt; base = got_q.size();
    seen_last = 1'b0; wrapped = 1'b0; bad = 0;
    pulse_start(1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (seen_last && rom_addr == 7'd0) wrapped = 1'b1;
      if (rom_addr == 7'd63) seen_last = 1'b1;
      if (done || error) break;
    end
    n_cmp++; if (got_q.size() - base !== 64) begin n_fail++; $display("FAIL noend_count: got %0d want 64", got_q.size() - base); end
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      if (got_q[base + i] !== {b, ~b}) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL noend_cmds: got %0d wrong want 0 wrong", bad); end
    n_cmp++; if ({done, entry_idx, rom_addr} !== {1'b1, 6'd63, 7'd63}) begin n_fail++; $display("FAIL noend_end: got done=%b idx=%0d addr=%0d want 1 63 63", done, entry_idx, rom_addr); end
    n_cmp++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL noend_wrap: got wrap to 0 want none"); end
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h7788;
    plan_n = 0; plan_base = resp_cnt;
    cmd_ready = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) break;
      @(negedge clk);
    end
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_before: got %b want 1", cmd_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({cmd_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_outputs: got v=%b busy=%b want 0 0", cmd_valid, busy); end
    n_cmp++; if ({dbg_state, entry_idx, rom_addr, cmd_reg} !== {S_IDLE, 6'd0, 7'd0, 8'd0}) begin n_fail++; $display("FAIL rstmid_state: got st=%0d idx=%0d addr=%h reg=%h want 0 0 00 00", dbg_state, entry_idx, rom_addr, cmd_reg); end
    @(negedge clk);
    reset = 1'b0; cmd_ready = 1'b1; base = got_q.size();
    pulse_start(1'b0);
    n_cmp++; if ({dbg_state, rom_addr} !== {S_FETCH, 7'd0}) begin n_fail++; $display("FAIL rstmid_refetch: got st=%0d addr=%h want st=1 addr=00", dbg_state, rom_addr); end
    wait_end(100, ok);
    n_cmp++; if (got_q.size() - base !== 1 || got_q[base] !== 16'h7788 || done !== 1'b1) begin n_fail++; $display("FAIL rstmid_rerun: got n=%0d %h done=%b want n=1 7788 done=1", got_q.size() - base, got_q[base], done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; profile_sel = 1'b0; cmd_ready = 1'b1;
    fill_rom(16'hFFFF);
    repeat (3) @(negedge clk);
    test_reset;
    test_single_write;
    test_delay;
    test_retry;
    test_nack_error;
    test_profile_busy;
    test_no_end;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_reg_sequencer.md
SCCB_REG_SEQUENCER -- requirements
Module: sccb_reg_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, camera register address width.
REQ-002 SHALL have parameter DATA_W, default 8, camera register data width.
REQ-003 SHALL have parameter IDX_W, default 6, entry index width; each profile holds 2^IDX_W entries.
REQ-004 SHALL have parameter PROF_W, default 1, profile select width.
REQ-005 SHALL have parameter DELAY_UNIT, default 1000, clk cycles per delay unit.
REQ-006 SHALL have parameter MAX_RETRY, default 3, NACK retries per entry.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to run a profile.
REQ-010 profile_sel  in  PROF_W  profile to run, sampled on accepted start.
REQ-011 rom_addr  out  PROF_W+IDX_W  table address, {profile, index}.
REQ-012 rom_data  in  ADDR_W+DATA_W  table word {reg, data}, valid one cycle after rom_addr.
REQ-013 cmd_valid  out  1  write command pending to SCCB master.
REQ-014 cmd_ready  in  1  SCCB master accepts the command.
REQ-015 cmd_reg / cmd_data  out  ADDR_W / DATA_W  register address and value; stable while cmd_valid.
REQ-016 xfer_done / xfer_nack  in  1 / 1  transfer complete OK / transfer NACKed.
REQ-017 busy, done, error  out  1 each  sequence running / completed / aborted.
REQ-018 entry_idx  out  IDX_W  current index.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DECODE, ISSUE, WAIT_XFER, DELAY, DONE and ERROR.
REQ-020 start in IDLE, DONE or ERROR: latch profile_sel, index=0, retry=0, clear done/error, go to FETCH; start in any other state is ignored.
REQ-021 FETCH (1 cycle): drive rom_addr={profile,index}, go to DECODE; DECODE samples rom_data.
REQ-022 Encoding: reg=all-ones and data=all-ones -> END; reg=all-ones and data otherwise -> DELAY of data units; any other word -> register write.
REQ-023 END -> DONE; done=1, busy=0, held until next start or reset.
REQ-024 DELAY with data=0 -> advance immediately; otherwise wait data*DELAY_UNIT cycles (prescaler plus unit counter, no multiplier), then advance.
REQ-025 Write: latch cmd_reg/cmd_data, go to ISSUE; cmd_valid=1 until the cycle cmd_ready=1, then go to WAIT_XFER with cmd_valid=0 next cycle.
REQ-026 WAIT_XFER, xfer_nack=1: if retry<MAX_RETRY, increment retry and return to ISSUE with the same command; else go to ERROR (error=1, busy=0).
REQ-027 WAIT_XFER, xfer_done=1 and xfer_nack=0: retry=0, advance.
REQ-028 xfer_nack and xfer_done in the same cycle SHALL be treated as a NACK.
REQ-029 Advance: if index=2^IDX_W-1 -> DONE (implicit end, no wrap); else index+1 -> FETCH.
REQ-030 busy=1 in every state except IDLE, DONE and ERROR.
REQ-031 entry_idx SHALL equal the current index.
REQ-032 xfer_done and xfer_nack outside WAIT_XFER, and cmd_ready outside ISSUE, SHALL be ignored.
REQ-033 Minimum cost of one write entry: FETCH + DECODE + ISSUE (1 cycle if ready) + WAIT_XFER.

Reset
REQ-034 reset SHALL force IDLE at any time, including mid-transfer or mid-delay.
REQ-035 Reset values: cmd_valid=0, busy=0, done=0, error=0, index=0, retry=0, cmd_reg=0, cmd_data=0, rom_addr=0, delay counters=0.
REQ-036 The first start after reset SHALL begin at index 0.

Verification
REQ-037 Profile 0 = {1280, FFFF}, start, cmd_ready and xfer_done immediate -> one command reg=12 data=80; done=1 after index 1.
REQ-038 Entry FF05, DELAY_UNIT=4 -> exactly 20 cycles in DELAY, then next FETCH.
REQ-039 xfer_nack on 3 tries, then xfer_done -> 4 identical commands, no error; 4 NACKs -> error=1, entry_idx frozen.
REQ-040 profile_sel=1 -> rom_addr MSB=1 throughout; start while busy -> no effect.
REQ-041 Table with no END entry -> 64 writes, then done=1, rom_addr never wraps to 0.
REQ-042 reset asserted while cmd_valid=1 -> cmd_valid=0 immediately; next start re-fetches index 0.
